// File: rtl/fpu_disp_pkg.sv
// rtl/fpu_disp_pkg.sv - shared types, segment codes and helpers for the FPU result display
package fpu_disp_pkg;

  typedef enum logic [1:0] {
    PAGE_HI  = 2'd0,
    PAGE_LO  = 2'd1,
    PAGE_CNT = 2'd2
  } page_t;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [17:0] CNT_MAX = 18'h3FFFF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - push-button synchronizer, debouncer and press pulse generator
module key_debounce
  import fpu_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The count holds the number of consecutive samples that disagreed with the
  // accepted level; reaching DEBOUNCE_CYCLES samples flips the level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      sync1   <= i_key_n;
      sync2   <= sync1;
      o_press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level   <= sync2;
        cnt     <= '0;
        o_press <= !sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_result_display.sv
// rtl/fpu_result_display.sv - captures FPU results and shows them on HEX, LEDR and LEDG
module fpu_result_display
  import fpu_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_z,
  input  logic        i_overflow,
  input  logic        i_underflow,
  input  logic        i_zero,
  input  logic [1:0]  i_key_n,
  output logic [17:0] o_ledr,
  output logic [8:0]  o_ledg,
  output logic [55:0] o_hex
);

  logic        press0, press1, both;
  logic        capture;
  logic [31:0] z_q;
  logic        ovf_q, unf_q, zero_q;
  logic        sticky_ovf, sticky_unf;
  logic [17:0] cnt_q;
  logic        hold_q;
  page_t       page_q, page_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_n(i_key_n[0]), .o_press(press0)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_n(i_key_n[1]), .o_press(press1)
  );

  assign both    = press0 && press1;
  assign capture = i_valid && !hold_q;
  assign o_ready = !hold_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      z_q    <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (capture) begin
      z_q    <= i_z;
      ovf_q  <= i_overflow;
      unf_q  <= i_underflow;
      zero_q <= i_zero;
    end
  end

  // A two-key chord clears the statistics and beats a same-cycle capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
      cnt_q      <= '0;
    end else if (both) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
      cnt_q      <= '0;
    end else if (capture) begin
      sticky_ovf <= sticky_ovf | i_overflow;
      sticky_unf <= sticky_unf | i_underflow;
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 18'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      page_q <= PAGE_HI;
      hold_q <= 1'b0;
    end else begin
      page_q <= page_d;
      if (press1 && !press0) hold_q <= !hold_q;
    end
  end

  always_comb begin
    page_d = page_q;
    if (press0 && !press1) begin
      case (page_q)
        PAGE_HI: page_d = PAGE_LO;
        PAGE_LO: page_d = PAGE_CNT;
        default: page_d = PAGE_HI;
      endcase
    end
  end

  always_comb begin
    o_ledr = '0;
    case (page_q)
      PAGE_HI: o_ledr = z_q[31:14];
      PAGE_LO: o_ledr = {4'b0, z_q[13:0]};
      default: o_ledr = cnt_q;
    endcase
  end

  assign o_ledg = {hold_q, 1'b0, page_q, sticky_unf, sticky_ovf, ovf_q, unf_q, zero_q};

  for (genvar k = 0; k < 8; k++) begin : g_hex
    assign o_hex[7*k +: 7] = hex_to_seg(z_q[4*k +: 4]);
  end

endmodule

// File: tb/tb_fpu_result_display.sv
// tb/tb_fpu_result_display.sv - randomized self-checking bench with a behavioural display model
module tb_fpu_result_display;

  localparam int D = 4;
  localparam int SETTLE = D + 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] z = '0;
  logic        ovf = 1'b0, unf = 1'b0, zr = 1'b0;
  logic [1:0]  key_n = 2'b11;
  logic        ready;
  logic [17:0] ledr;
  logic [8:0]  ledg;
  logic [55:0] hex;

  fpu_result_display #(.DEBOUNCE_CYCLES(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_z(z),
    .i_overflow(ovf), .i_underflow(unf), .i_zero(zr), .i_key_n(key_n),
    .o_ledr(ledr), .o_ledg(ledg), .o_hex(hex)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [31:0] m_z;
  bit          m_ovf, m_unf, m_zero, m_sovf, m_sunf, m_hold;
  int          m_cnt, m_page;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] exp_ledr();
    if (m_page == 0) return m_z / (1 << 14);
    if (m_page == 1) return 18'(m_z % (1 << 14));
    return 18'(m_cnt);
  endfunction

  function automatic logic [8:0] exp_ledg();
    return 9'(m_zero + 2*m_unf + 4*m_ovf + 8*m_sovf + 16*m_sunf + 32*m_page + 256*m_hold);
  endfunction

  function automatic logic [55:0] exp_hex();
    logic [55:0] h;
    logic [31:0] v;
    v = m_z;
    for (int k = 0; k < 8; k++) begin
      h[7*k +: 7] = seg_tab[v % 16];
      v = v / 16;
    end
    return h;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "/ready"}, 64'(ready), 64'(!m_hold));
    chk({tag, "/ledr"}, 64'(ledr), 64'(exp_ledr()));
    chk({tag, "/ledg"}, 64'(ledg), 64'(exp_ledg()));
    chk({tag, "/hex"}, 64'(hex), 64'(exp_hex()));
  endtask

  task automatic model_reset();
    m_z = '0; m_ovf = 0; m_unf = 0; m_zero = 0; m_sovf = 0; m_sunf = 0;
    m_hold = 0; m_cnt = 0; m_page = 0;
  endtask

  task automatic capture(input logic [31:0] zv, input bit o, input bit u, input bit zz, input bit v);
    @(negedge clk);
    z = zv; ovf = o; unf = u; zr = zz; valid = v;
    @(negedge clk);
    valid = 1'b0;
    if (v && !m_hold) begin
      m_z = zv; m_ovf = o; m_unf = u; m_zero = zz;
      m_sovf |= o; m_sunf |= u;
      if (m_cnt < 18'h3FFFF) m_cnt++;
    end
    check_all("cap");
  endtask

  task automatic press(input logic [1:0] mask);
    @(negedge clk);
    key_n = ~mask;
    repeat (SETTLE) @(negedge clk);
    key_n = 2'b11;
    repeat (SETTLE) @(negedge clk);
    if (mask == 2'b11) begin
      m_sovf = 0; m_sunf = 0; m_cnt = 0;
    end else if (mask == 2'b01) begin
      m_page = (m_page + 1) % 3;
    end else if (mask == 2'b10) begin
      m_hold = !m_hold;
    end
    check_all("press");
  endtask

  task automatic glitch(input logic [1:0] mask, input int len);
    @(negedge clk);
    key_n = ~mask;
    repeat (len) @(negedge clk);
    key_n = 2'b11;
    repeat (SETTLE) @(negedge clk);
    check_all("glitch");
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("rst_init");
    rst_n = 1'b1;

    capture(32'h41A20000, 0, 0, 0, 1);
    chk("plan_ledr", 64'(ledr), 64'h10688);
    chk("plan_hex", 64'(hex), {8'h0, 7'h19, 7'h79, 7'h08, 7'h24, 7'h40, 7'h40, 7'h40, 7'h40});

    capture(32'hC0490FDB, 0, 0, 0, 1);
    // Press latency: page must change exactly at the 7th edge after the fall.
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("lat_before", 64'(ledg[6:5]), 64'd0);
    @(negedge clk);
    chk("lat_after", 64'(ledg[6:5]), 64'd1);
    repeat (3) @(negedge clk);
    key_n[0] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    m_page = 1;
    check_all("page1");
    chk("plan_lo", 64'(ledr), 64'h00FDB);
    press(2'b01);
    chk("plan_cnt", 64'(ledr), 64'd2);
    press(2'b01);
    chk("plan_hi", 64'(ledr), 64'h30124);

    press(2'b10);
    capture(32'h3F800000, 0, 0, 0, 1);
    press(2'b10);

    capture(32'h7F800000, 1, 0, 0, 1);
    capture(32'h12345678, 0, 0, 0, 1);
    press(2'b11);

    for (int l = 1; l < D; l++) glitch(2'b01, l);

    press(2'b01);
    press(2'b01);
    press(2'b10);
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();
    key_n = 2'b11;
    repeat (SETTLE) @(negedge clk);
    check_all("post_rst");

    for (int i = 0; i < 150; i++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 4 || (act == 9 && ($urandom % 4) != 0)) begin
        capture($urandom, ($urandom % 4) == 0, ($urandom % 4) == 0, $urandom % 2,
                ($urandom % 5) != 0);
      end else if (act == 5) begin
        press(2'b01);
      end else if (act == 6) begin
        press(2'b10);
      end else if (act == 7) begin
        press(2'b11);
      end else if (act == 8) begin
        glitch(2'($urandom_range(1, 3)), $urandom_range(1, D - 1));
      end else begin
        do_reset();
        @(negedge clk);
        check_all("rnd_rst");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
